// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA timing from a 50 MHz clock, with delayed sync/blank outputs.
// Rev 1.0 - initial release.
`default_nettype none

module vga_timing_gen #(
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned CTRL_DELAY = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pix_en,
  output logic       vga_clk,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       sync_n,
  output logic       line_start,
  output logic       frame_start
);

  localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
  localparam logic [9:0] H_ACT_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_ACT_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] H_LAST      = 10'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
  localparam logic [9:0] V_ACT_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_ACT_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0] V_LAST      = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  // {hsync, vsync, blank_n} while idle
  localparam logic [2:0] CTRL_IDLE   = 3'b110;

  logic       phase_q;
  logic       pix_en_q;
  logic       vga_clk_q;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [2:0] ctrl_raw;
  logic [2:0] ctrl_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q       <= 1'b0;
      pix_en_q      <= 1'b0;
      vga_clk_q     <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      phase_q       <= ~phase_q;
      pix_en_q      <= phase_q;
      vga_clk_q     <= phase_q;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_en_q) begin
      if (x_q == H_LAST) begin
        x_d          = 10'd0;
        line_start_d = 1'b1;
        if (y_q == V_LAST) begin
          y_d           = 10'd0;
          frame_start_d = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  always_comb begin
    ctrl_raw[2] = (x_q >= H_SYNC_END);
    ctrl_raw[1] = (y_q >= V_SYNC_END);
    ctrl_raw[0] = (x_q >= H_ACT_START) && (x_q < H_ACT_END) &&
                  (y_q >= V_ACT_START) && (y_q < V_ACT_END);
  end

  // The delay line runs every clk so it matches the drawing pipeline latency in clks, not pixels.
  generate
    if (CTRL_DELAY == 0) begin : g_bypass
      assign ctrl_out = ctrl_raw;
    end else begin : g_delay
      logic [2:0] dly_q [CTRL_DELAY];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < int'(CTRL_DELAY); i++) dly_q[i] <= CTRL_IDLE;
        end else begin
          dly_q[0] <= ctrl_raw;
          for (int i = 1; i < int'(CTRL_DELAY); i++) dly_q[i] <= dly_q[i-1];
        end
      end

      assign ctrl_out = dly_q[CTRL_DELAY-1];
    end
  endgenerate

  assign x           = x_q;
  assign y           = y_q;
  assign pix_en      = pix_en_q;
  assign vga_clk     = vga_clk_q;
  assign hsync       = ctrl_out[2];
  assign vsync       = ctrl_out[1];
  assign blank_n     = ctrl_out[0];
  assign sync_n      = 1'b0;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: reduced-geometry timing checked against a clock-count reference model.
// Rev 1.0 - initial release.
`default_nettype none

module tb_vga_timing_gen;

  localparam int HS = 4, HB = 3, HA = 8, HF = 2;
  localparam int VS = 2, VB = 2, VA = 5, VF = 2;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int DA = 4;
  localparam int DB = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         n_edges;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  logic [9:0] a_x, a_y, b_x, b_y;
  logic       a_pe, a_vc, a_hs, a_vs, a_bl, a_sn, a_ls, a_fs;
  logic       b_pe, b_vc, b_hs, b_vs, b_bl, b_sn, b_ls, b_fs;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF), .CTRL_DELAY(DA)
  ) u_dut_a (
    .clk(clk), .rst(rst), .x(a_x), .y(a_y), .pix_en(a_pe), .vga_clk(a_vc),
    .hsync(a_hs), .vsync(a_vs), .blank_n(a_bl), .sync_n(a_sn),
    .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF), .CTRL_DELAY(DB)
  ) u_dut_b (
    .clk(clk), .rst(rst), .x(b_x), .y(b_y), .pix_en(b_pe), .vga_clk(b_vc),
    .hsync(b_hs), .vsync(b_vs), .blank_n(b_bl), .sync_n(b_sn),
    .line_start(b_ls), .frame_start(b_fs)
  );

  // Clock edges elapsed since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) n_edges <= 0;
    else     n_edges <= n_edges + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, n_edges);
  endtask

  // Pixel advances happen on edges 3, 5, 7, ... after release.
  function automatic int pix_count(input int n);
    return (n >= 3) ? (n - 1) / 2 : 0;
  endfunction

  function automatic logic [2:0] raw_ctrl(input int n);
    int p, xx, yy;
    p  = pix_count(n);
    xx = p % HT;
    yy = (p / HT) % VT;
    return {xx >= HS, yy >= VS,
            (xx >= HS + HB) && (xx < HS + HB + HA) && (yy >= VS + VB) && (yy < VS + VB + VA)};
  endfunction

  task automatic check_dut(input string nm, input int d, input int n,
                           input logic [9:0] gx, input logic [9:0] gy,
                           input logic gpe, input logic gvc, input logic ghs,
                           input logic gvs, input logic gbl, input logic gsn,
                           input logic gls, input logic gfs);
    int p;
    logic [2:0] ctl;
    p   = pix_count(n);
    ctl = (n - d < 0) ? 3'b110 : raw_ctrl(n - d);
    chk({nm, ".x"},           int'(gx),  p % HT);
    chk({nm, ".y"},           int'(gy),  (p / HT) % VT);
    chk({nm, ".pix_en"},      int'(gpe), int'(n >= 2 && n % 2 == 0));
    chk({nm, ".vga_clk"},     int'(gvc), (n >= 1) ? (n - 1) % 2 : 0);
    chk({nm, ".hsync"},       int'(ghs), int'(ctl[2]));
    chk({nm, ".vsync"},       int'(gvs), int'(ctl[1]));
    chk({nm, ".blank_n"},     int'(gbl), int'(ctl[0]));
    chk({nm, ".sync_n"},      int'(gsn), 0);
    chk({nm, ".line_start"},  int'(gls), int'(n >= 3 && n % 2 == 1 && p % HT == 0));
    chk({nm, ".frame_start"}, int'(gfs), int'(n >= 3 && n % 2 == 1 && p % (HT * VT) == 0));
  endtask

  task automatic check_all();
    check_dut("A", DA, n_edges, a_x, a_y, a_pe, a_vc, a_hs, a_vs, a_bl, a_sn, a_ls, a_fs);
    check_dut("B", DB, n_edges, b_x, b_y, b_pe, b_vc, b_hs, b_vs, b_bl, b_sn, b_ls, b_fs);
  endtask

  always @(negedge clk) check_all();

  task automatic pulse_reset(input int hold);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all();
    repeat (hold) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  int run_len;
  int line_pulses;

  initial begin
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    // More than two reduced frames before the first mid-frame reset.
    line_pulses = 0;
    repeat (900) begin
      @(negedge clk);
      if (a_ls) line_pulses++;
    end
    chk("line_start_count", line_pulses, pix_count(899) / HT);
    for (int k = 0; k < 8; k++) begin
      pulse_reset(int'($urandom_range(1, 4)));
      run_len = int'($urandom_range(20, 700));
      repeat (run_len) @(negedge clk);
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
